and1_or1_xor1: RTL and testbench

AND1_OR1_XOR1 -- requirements
Module: and1_or1_xor1

---
 rtl/and1_or1_xor1_if.sv | 36 +++
 rtl/and1_or1_xor1.sv | 94 +++++++++
 tb/tb_and1_or1_xor1.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/and1_or1_xor1_if.sv
// rtl/and1_or1_xor1_if.sv - operand/result bundle for and1_or1_xor1; parity member present only with AND1_OR1_XOR1_PARITY_EN
interface and1_or1_xor1_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             cout;
`ifdef AND1_OR1_XOR1_PARITY_EN
    logic             parity;

    modport master (
        output in_valid, sel, a, b, c,
        input  out_valid, y, cout, parity
    );

    modport slave (
        input  in_valid, sel, a, b, c,
        output out_valid, y, cout, parity
    );
`else
    modport master (
        output in_valid, sel, a, b, c,
        input  out_valid, y, cout
    );

    modport slave (
        input  in_valid, sel, a, b, c,
        output out_valid, y, cout
    );
`endif
endinterface

// File: rtl/and1_or1_xor1.sv
// rtl/and1_or1_xor1.sv - registered AND/OR3/XOR3/ripple-ADD unit, one-cycle latency; optional parity output via AND1_OR1_XOR1_PARITY_EN
module and1_or1_xor1 #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    and1_or1_xor1_if.slave  bus
);

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;

    function automatic logic and1(input logic p, input logic q);
        return p & q;
    endfunction

    function automatic logic or1(input logic p, input logic q, input logic r);
        return p | q | r;
    endfunction

    function automatic logic xor1(input logic p, input logic q, input logic r);
        return p ^ q ^ r;
    endfunction

    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;
    logic [WIDTH-1:0] xor_res;
    logic [WIDTH-1:0] sum_res;
    logic             carry;
    logic [WIDTH-1:0] y_next;
    logic             cout_next;

    logic [WIDTH-1:0] y_q;
    logic             cout_q;
    logic             out_valid_q;

    // Every function, including the adder, is composed bit-by-bit from the three cells.
    always_comb begin
        and_res = '0;
        or_res  = '0;
        xor_res = '0;
        sum_res = '0;
        carry   = bus.c[0];
        for (int i = 0; i < WIDTH; i++) begin
            and_res[i] = and1(bus.a[i], bus.b[i]);
            or_res[i]  = or1(bus.a[i], bus.b[i], bus.c[i]);
            xor_res[i] = xor1(bus.a[i], bus.b[i], bus.c[i]);
            sum_res[i] = xor1(bus.a[i], bus.b[i], carry);
            carry      = or1(and1(bus.a[i], bus.b[i]),
                             and1(bus.a[i], carry),
                             and1(bus.b[i], carry));
        end
    end

    always_comb begin
        y_next    = sum_res;
        cout_next = 1'b0;
        case (bus.sel)
            SEL_AND: y_next = and_res;
            SEL_OR:  y_next = or_res;
            SEL_XOR: y_next = xor_res;
            default: begin
                y_next    = sum_res;
                cout_next = carry;
            end
        endcase
    end

    // Results update only on valid; otherwise y/cout hold and out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                y_q    <= y_next;
                cout_q <= cout_next;
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;

`ifdef AND1_OR1_XOR1_PARITY_EN
    // Derived from the y register, so it shares y's timing and reset value.
    assign bus.parity = ^y_q;
`endif

endmodule

// File: tb/tb_and1_or1_xor1.sv
// tb/tb_and1_or1_xor1.sv - randomized and directed checks of and1_or1_xor1 against an arithmetic reference model
module tb_and1_or1_xor1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    and1_or1_xor1_if #(.WIDTH(8)) bus8 ();
    and1_or1_xor1_if #(.WIDTH(4)) bus4 ();

    and1_or1_xor1 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    and1_or1_xor1 #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_y;
    logic       m_cout;
    logic       m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_op(input logic [1:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
        case (s)
            2'd0:    return {1'b0, a & b};
            2'd1:    return {1'b0, a | b | c};
            2'd2:    return {1'b0, a ^ b ^ c};
            default: return 9'(int'(a) + int'(b) + int'(c[0]));
        endcase
    endfunction

    task automatic check_outs(input string tag);
        check({tag, ".y"},   32'(bus8.y),         32'(m_y));
        check({tag, ".cout"}, 32'(bus8.cout),     32'(m_cout));
        check({tag, ".ov"},  32'(bus8.out_valid), 32'(m_ov));
`ifdef AND1_OR1_XOR1_PARITY_EN
        check({tag, ".par"}, 32'(bus8.parity),    32'(^m_y));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        bus8.in_valid = v;
        bus8.sel      = s;
        bus8.a        = a;
        bus8.b        = b;
        bus8.c        = c;
        @(posedge clk);
        #1;
        if (v) {m_cout, m_y} = ref_op(s, a, b, c);
        m_ov = v;
        check_outs(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.sel      = 2'd0;
        bus8.a        = '0;
        bus8.b        = '0;
        bus8.c        = '0;
        bus4.in_valid = 1'b0;
        bus4.sel      = 2'd3;
        bus4.a        = '0;
        bus4.b        = '0;
        bus4.c        = '0;
        m_y = 8'h00; m_cout = 1'b0; m_ov = 1'b0;

        #12;
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("add", 1'b1, 2'd3, 8'h02, 8'h02, 8'h00);
        check("add_const.y", 32'(bus8.y), 32'h04);
        step("add_ovf", 1'b1, 2'd3, 8'hFF, 8'h01, 8'h01);
        check("ovf_const.y", 32'(bus8.y), 32'h01);
        check("ovf_const.cout", 32'(bus8.cout), 32'h1);

        step("and", 1'b1, 2'd0, 8'hF0, 8'hCC, 8'hAA);
        check("and_const.y", 32'(bus8.y), 32'hC0);
        step("or", 1'b1, 2'd1, 8'hF0, 8'hCC, 8'hAA);
        check("or_const.y", 32'(bus8.y), 32'hFE);
        step("xor", 1'b1, 2'd2, 8'hF0, 8'hCC, 8'hAA);
        check("xor_const.y", 32'(bus8.y), 32'h96);

        for (int s = 0; s < 4; s++)
            step("b2b", 1'b1, 2'(s), 8'h5A, 8'hC3, 8'h81);
        step("hold", 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        check("hold_const.y", 32'(bus8.y), 32'h1E);
        step("hold2", 1'b0, 2'd1, 8'hFF, 8'hFF, 8'hFF);

        for (int i = 0; i < 300; i++)
            step("rand", ($urandom % 4) != 0, 2'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom));

        // Reset mid-stream with a valid operation present.
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.sel      = 2'd3;
        bus8.a        = 8'h37;
        bus8.b        = 8'hA9;
        bus8.c        = 8'h01;
        rst_n         = 1'b0;
        m_y = 8'h00; m_cout = 1'b0; m_ov = 1'b0;
        #1;
        check_outs("rst_async");
        @(posedge clk);
        #1;
        check_outs("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs("rst_release");
        step("after_rst", 1'b1, 2'd3, 8'h10, 8'h20, 8'h01);

        // Exhaustive 4-bit ADD; upper c bits are noise the adder must ignore.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    @(negedge clk);
                    bus4.in_valid = 1'b1;
                    bus4.sel      = 2'd3;
                    bus4.a        = 4'(a);
                    bus4.b        = 4'(b);
                    bus4.c        = {3'($urandom), 1'(ci)};
                    @(posedge clk);
                    #1;
                    check("add4", 32'({bus4.cout, bus4.y}), 32'(a + b + ci));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
